display_scan_scheduler: RTL and testbench
=========================================

// Module: display_scan_scheduler
// PURPOSE
//  Shares the 4-digit seven-segment display between three 8-bit sources: output register, program counter, bus monitor.
//  Picks the source (fixed or timed auto-rotate) and converts the value to BCD with an 8-step sequential double-dabble.
//  Scans digits from one clock using a refresh divider, so no fast_clk is needed.
//  Sits between the datapath registers and the board display pins.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles per digit scan step (>=2)
//  SLOT_FRAMES  250    full 4-digit frames each source is shown in auto mode (>=1)
// PORTS
//  clk        in   1   system clock
//  clear      in   1   reset: synchronous, active-high
//  src_valid  in   3   per-source valid; bit0 out_reg, bit1 PC, bit2 bus
//  src_data   in   24  [7:0] out_reg, [15:8] PC, [23:16] bus
//  mode       in   2   0/1/2 = fixed source 0/1/2; 3 = auto-rotate
//  display    out  7   segments a..g = bit6..bit0, active-high
//  display_en out  4   digit enables, active-low one-hot; bit0 = units, bit3 = source tag
//  cur_src    out  2   source currently shown
//  conv_busy  out  1   high while a BCD conversion runs
// BEHAVIOUR
//  Reset: scan_idx=0, display_en=4'b1110, cur_src=0, conv_busy=0, FSM=IDLE, all divider/slot counters 0,
//   shown digits = 0, shadow value = 0, display = 7'b1111110 ('0' on units digit).
//  Scan:
//   - Divider counts 0..REFRESH_DIV-1. On wrap, scan_idx advances 0->1->2->3->0.
//   - display_en = ~(1<<scan_idx). A frame ends when scan_idx wraps 3->0.
//  Select, mode 0..2: cur_src = mode; takes effect the next clk.
//  Select, mode 3:
//   - Slot counter counts frames. At SLOT_FRAMES it clears and cur_src moves to the next index (mod 3) with src_valid=1.
//   - If no other source is valid, cur_src holds.
//   - Changing mode clears the slot counter.
//  Conversion FSM IDLE -> SHIFT -> COMMIT -> IDLE:
//   - Start condition: in IDLE, and cur_src changed or src_data[cur_src] differs from the shadow value.
//     On start, latch the value into the shadow and a 20-bit shift reg ([7:0]=value). conv_busy=1.
//   - SHIFT, 8 cycles: each cycle, add 3 to every BCD nibble ([11:8],[15:12],[19:16]) that is >=5, then shift left 1.
//   - COMMIT, 1 cycle: copy [19:8] to the shown digits (hundreds/tens/units); conv_busy=0.
//   - Latency from start to updated digits = 10 clk.
//   - Input changes during SHIFT do not abort the conversion. The compare in the next IDLE restarts it,
//     so the final value is always shown.
//  Digit rendering:
//   - idx0 = units, always drawn. idx1 = tens, blank (7'b0) if hundreds==0 and tens==0. idx2 = hundreds, blank if 0.
//   - idx3 = source tag: 'o' 7'b0011101, 'P' 7'b1100111, 'b' 7'b0011111.
//   - If src_valid[cur_src]==0, all four digits show '-' (7'b0000001). Conversion still runs.
//   - 0..9 use the standard table: 0=1111110, 1=0110000, ..., 9=1111011. A nibble >9 cannot occur; default is 7'b0.
//   - display is combinational from scan_idx, the shown digits and cur_src; no added latency.
//  Simultaneous events:
//   - Source switch and data change in the same cycle cause one conversion, of the new source.
//   - Frame wrap and slot expiry in the same cycle: the new source is shown from the next frame.
//  clear mid-conversion: FSM returns to IDLE, partial result is dropped, reset values apply the next cycle.
// STRUCTURE
//  display_pkg:
//   - SRC_OUT/SRC_PC/SRC_BUS ids
//   - FSM state encoding
//   - seven-seg constants: digits 0-9, SEG_BLANK, SEG_DASH, tag glyphs
//  Sub-module bin2bcd_seq:
//   - holds the shift reg and the SHIFT/COMMIT steps
//   - start/busy/done handshake; 8-bit in, 12-bit BCD out
//  The top level keeps the divider, slot counter, source select and render mux.
// TESTING (bench REFRESH_DIV=4, SLOT_FRAMES=2)
//  1) clear 1 cycle, mode=0, src_valid=3'b001, data0=8'd0
//     -> display_en cycles 1110,1101,1011,0111 every 4 clk; units shows 1111110; idx1/idx2 blank; idx3 shows 'o'.
//  2) data0 set to 8'd255 -> conv_busy high exactly 9 clk; digits 2,5,5 after 10 clk; units shows 1011011.
//  3) data0 set to 8'd7, then 8'd42 two clk later -> 7 committed first, then an automatic restart;
//     42 shown 20 clk after the first change; hundreds blank.
//  4) mode=3, src_valid=3'b101 -> cur_src goes 0,2,0 every 2 frames (32 clk), skipping PC; tag shows 'o','b','o'.
//  5) mode=1, src_valid[1]=0 -> all digits show 7'b0000001. Set valid -> PC value with tag 'P'.
//  6) clear asserted at SHIFT cycle 4 -> next cycle conv_busy=0, digits 0, display_en=1110; no stale commit afterwards.

Source files
------------

// File: rtl/display_pkg.sv
// Shared source ids, conversion FSM states and seven-segment glyphs for the
// display scan scheduler and its sequential binary-to-BCD converter.
package display_pkg;

    localparam logic [1:0] SRC_OUT = 2'd0;
    localparam logic [1:0] SRC_PC  = 2'd1;
    localparam logic [1:0] SRC_BUS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Segments a..g on bits 6..0, active-high
    localparam logic [6:0] SEG_0       = 7'b1111110;
    localparam logic [6:0] SEG_1       = 7'b0110000;
    localparam logic [6:0] SEG_2       = 7'b1101101;
    localparam logic [6:0] SEG_3       = 7'b1111001;
    localparam logic [6:0] SEG_4       = 7'b0110011;
    localparam logic [6:0] SEG_5       = 7'b1011011;
    localparam logic [6:0] SEG_6       = 7'b1011111;
    localparam logic [6:0] SEG_7       = 7'b1110000;
    localparam logic [6:0] SEG_8       = 7'b1111111;
    localparam logic [6:0] SEG_9       = 7'b1111011;
    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [6:0] SEG_DASH    = 7'b0000001;
    localparam logic [6:0] SEG_TAG_OUT = 7'b0011101;
    localparam logic [6:0] SEG_TAG_PC  = 7'b1100111;
    localparam logic [6:0] SEG_TAG_BUS = 7'b0011111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] src_tag(input logic [1:0] s);
        case (s)
            SRC_OUT: return SEG_TAG_OUT;
            SRC_PC:  return SEG_TAG_PC;
            SRC_BUS: return SEG_TAG_BUS;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Next valid source in rotation order; holds when no other source is valid
    function automatic logic [1:0] next_src(input logic [1:0] cur, input logic [2:0] valid);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (cur == SRC_BUS) ? SRC_OUT : cur + 2'd1;
        c2 = (c1 == SRC_BUS) ? SRC_OUT : c1 + 2'd1;
        if (valid[c1]) begin
            return c1;
        end else if (valid[c2]) begin
            return c2;
        end else begin
            return cur;
        end
    endfunction

    // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int n = 0; n < 3; n++) begin
            if (a[8+4*n +: 4] >= 4'd5) begin
                a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
            end else begin
                a[8+4*n +: 4] = a[8+4*n +: 4];
            end
        end
        return {a[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit to 3-digit BCD converter: one load cycle, eight
// double-dabble shifts, then a commit cycle that updates the held digits.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        i_start,
    input  logic [7:0]  i_value,
    output logic        o_busy,
    output logic [11:0] o_bcd
);

    conv_state_e r_state;
    conv_state_e w_next_state;
    logic [2:0]  r_cnt;
    logic [19:0] r_shreg;
    logic [11:0] r_bcd;

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == 3'd7) begin
                    w_next_state = ST_COMMIT;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Shift register, step counter and committed digits
    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt   <= 3'd0;
            r_shreg <= 20'd0;
            r_bcd   <= 12'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_shreg <= {12'd0, i_value};
                        r_cnt   <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= dd_step(r_shreg);
                    r_cnt   <= r_cnt + 3'd1;
                end
                ST_COMMIT: r_bcd <= r_shreg[19:8];
                default:   r_cnt <= 3'd0;
            endcase
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/display_scan_scheduler.sv
// Multiplexes three 8-bit sources onto a 4-digit seven-segment display:
// refresh divider, source select / auto-rotate, BCD conversion and render mux.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int SLOT_FRAMES = 250
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [2:0]  src_valid,
    input  logic [23:0] src_data,
    input  logic [1:0]  mode,
    output logic [6:0]  display,
    output logic [3:0]  display_en,
    output logic [1:0]  cur_src,
    output logic        conv_busy
);

    localparam int DIV_W  = $clog2(REFRESH_DIV + 1);
    localparam int SLOT_W = $clog2(SLOT_FRAMES + 1);

    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_scan_idx;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_cur_src;
    logic [1:0]        r_mode_prev;
    logic [1:0]        r_conv_src;
    logic [7:0]        r_shadow;

    logic        w_div_wrap;
    logic        w_frame_end;
    logic [7:0]  w_sel_data;
    logic        w_start;
    logic        w_busy;
    logic [11:0] w_bcd;
    logic [6:0]  w_seg;

    assign w_div_wrap  = (r_div == DIV_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_div_wrap && (r_scan_idx == 2'd3);

    // Value of the currently selected source
    always_comb begin
        w_sel_data = 8'd0;
        case (r_cur_src)
            SRC_OUT: w_sel_data = src_data[7:0];
            SRC_PC:  w_sel_data = src_data[15:8];
            SRC_BUS: w_sel_data = src_data[23:16];
            default: w_sel_data = 8'd0;
        endcase
    end

    // A source switch and a data change in the same cycle start just one conversion
    assign w_start = !w_busy && ((r_cur_src != r_conv_src) || (w_sel_data != r_shadow));

    // Refresh divider and digit scan index
    always_ff @(posedge clk) begin
        if (clear) begin
            r_div      <= '0;
            r_scan_idx <= 2'd0;
        end else if (w_div_wrap) begin
            r_div      <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_div      <= r_div + DIV_W'(1);
        end
    end

    // Source select: fixed modes follow mode, auto mode rotates every SLOT_FRAMES frames
    always_ff @(posedge clk) begin
        if (clear) begin
            r_cur_src   <= SRC_OUT;
            r_mode_prev <= 2'd0;
            r_slot      <= '0;
        end else begin
            r_mode_prev <= mode;
            if (mode != 2'd3) begin
                r_cur_src <= mode;
                r_slot    <= '0;
            end else if (mode != r_mode_prev) begin
                r_slot    <= '0;
            end else if (w_frame_end) begin
                if (r_slot == SLOT_W'(SLOT_FRAMES - 1)) begin
                    r_slot    <= '0;
                    r_cur_src <= next_src(r_cur_src, src_valid);
                end else begin
                    r_slot    <= r_slot + SLOT_W'(1);
                end
            end
        end
    end

    // Shadow of the value and source handed to the converter
    always_ff @(posedge clk) begin
        if (clear) begin
            r_shadow   <= 8'd0;
            r_conv_src <= SRC_OUT;
        end else if (w_start) begin
            r_shadow   <= w_sel_data;
            r_conv_src <= r_cur_src;
        end
    end

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .clear   (clear),
        .i_start (w_start),
        .i_value (w_sel_data),
        .o_busy  (w_busy),
        .o_bcd   (w_bcd)
    );

    // Render mux with leading-zero blanking and invalid-source dashes
    always_comb begin
        w_seg = SEG_BLANK;
        if (!src_valid[r_cur_src]) begin
            w_seg = SEG_DASH;
        end else begin
            case (r_scan_idx)
                2'd0: w_seg = seg7(w_bcd[3:0]);
                2'd1: begin
                    if ((w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0)) begin
                        w_seg = SEG_BLANK;
                    end else begin
                        w_seg = seg7(w_bcd[7:4]);
                    end
                end
                2'd2: begin
                    if (w_bcd[11:8] == 4'd0) begin
                        w_seg = SEG_BLANK;
                    end else begin
                        w_seg = seg7(w_bcd[11:8]);
                    end
                end
                2'd3:    w_seg = src_tag(r_cur_src);
                default: w_seg = SEG_BLANK;
            endcase
        end
    end

    assign display    = w_seg;
    assign display_en = ~(4'b0001 << r_scan_idx);
    assign cur_src    = r_cur_src;
    assign conv_busy  = w_busy;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a behavioural model built from frame/slot arithmetic and decimal division.
module tb_display_scan_scheduler;

    localparam int RD = 4;
    localparam int SF = 2;

    logic        clk;
    logic        clear;
    logic [2:0]  src_valid;
    logic [23:0] src_data;
    logic [1:0]  mode;
    logic [6:0]  display;
    logic [3:0]  display_en;
    logic [1:0]  cur_src;
    logic        conv_busy;

    int n_cmp;
    int n_mis;

    // Reference model state
    int m_cyc;
    int m_cur;
    int m_prev_mode;
    int m_frames;
    int m_active;
    int m_cnt;
    int m_val;
    int m_shadow;
    int m_csrc;
    int m_h;
    int m_t;
    int m_u;

    logic [6:0] seg_tab [10];
    logic [6:0] tag_tab [3];

    display_scan_scheduler #(.REFRESH_DIV(RD), .SLOT_FRAMES(SF)) dut (
        .clk        (clk),
        .clear      (clear),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .mode       (mode),
        .display    (display),
        .display_en (display_en),
        .cur_src    (cur_src),
        .conv_busy  (conv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge
    task automatic model_edge();
        int sel;
        int found;
        int cand;
        if (clear) begin
            m_cyc = 0; m_cur = 0; m_prev_mode = 0; m_frames = 0;
            m_active = 0; m_cnt = 0; m_val = 0; m_shadow = 0; m_csrc = 0;
            m_h = 0; m_t = 0; m_u = 0;
        end else begin
            if (m_active != 0) begin
                m_cnt++;
                if (m_cnt == 9) begin
                    m_active = 0;
                    m_h = m_val / 100;
                    m_t = (m_val / 10) % 10;
                    m_u = m_val % 10;
                end
            end else begin
                sel = int'(src_data[m_cur*8 +: 8]);
                if (m_cur != m_csrc || sel != m_shadow) begin
                    m_active = 1; m_cnt = 0; m_val = sel; m_shadow = sel; m_csrc = m_cur;
                end
            end
            m_cyc++;
            if (mode != 2'd3) begin
                m_cur = int'(mode);
                m_frames = 0;
            end else if (int'(mode) != m_prev_mode) begin
                m_frames = 0;
            end else if ((m_cyc % (4 * RD)) == 0) begin
                m_frames++;
                if (m_frames == SF) begin
                    m_frames = 0;
                    found = 0;
                    for (int k = 1; k <= 2; k++) begin
                        cand = (m_cur + k) % 3;
                        if (found == 0 && src_valid[cand]) begin
                            m_cur = cand;
                            found = 1;
                        end
                    end
                end
            end
            m_prev_mode = int'(mode);
        end
    endtask

    function automatic logic [6:0] exp_seg();
        int scan;
        scan = (m_cyc / RD) % 4;
        if (!src_valid[m_cur]) return 7'b0000001;
        case (scan)
            0: return seg_tab[m_u];
            1: return (m_h == 0 && m_t == 0) ? 7'b0000000 : seg_tab[m_t];
            2: return (m_h == 0) ? 7'b0000000 : seg_tab[m_h];
            default: return tag_tab[m_cur];
        endcase
    endfunction

    task automatic tick();
        logic [3:0] en;
        @(posedge clk);
        model_edge();
        #1;
        en = ~(4'b0001 << ((m_cyc / RD) % 4));
        check_val("display_en", 32'(display_en), 32'(en));
        check_val("cur_src", 32'(cur_src), 32'(m_cur));
        check_val("conv_busy", 32'(conv_busy), 32'(m_active));
        check_val("display", 32'(display), 32'(exp_seg()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int busy_len;
        n_cmp = 0;
        n_mis = 0;
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1111011;
        tag_tab[0] = 7'b0011101; tag_tab[1] = 7'b1100111; tag_tab[2] = 7'b0011111;

        clear = 1'b1; mode = 2'd0; src_valid = 3'b001; src_data = 24'd0;
        #2;
        tick();
        check_val("reset_en", 32'(display_en), 32'(4'b1110));
        check_val("reset_units", 32'(display), 32'(7'b1111110));
        clear = 1'b0;
        run(20);

        // 255 -> busy exactly 9 cycles, digits 2,5,5
        src_data[7:0] = 8'd255;
        busy_len = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (conv_busy === 1'b1) busy_len++;
        end
        check_val("busy_len", 32'(busy_len), 32'd9);
        run(8);

        // 7 then 42 two cycles later: automatic restart
        src_data[7:0] = 8'd7;
        run(2);
        src_data[7:0] = 8'd42;
        run(30);

        // Auto-rotate skipping the invalid PC
        src_data[23:16] = 8'd130;
        src_valid = 3'b101; mode = 2'd3;
        run(110);

        // Invalid PC shows dashes, then valid PC
        src_data[15:8] = 8'd9;
        mode = 2'd1; src_valid = 3'b101;
        run(20);
        src_valid = 3'b111;
        run(20);

        // Clear in the middle of a conversion
        mode = 2'd0;
        run(12);
        src_data[7:0] = 8'd199;
        run(5);
        clear = 1'b1;
        tick();
        check_val("clr_busy", 32'(conv_busy), 32'd0);
        check_val("clr_en", 32'(display_en), 32'(4'b1110));
        clear = 1'b0;
        src_data[7:0] = 8'd0;
        run(25);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) src_data[8*$urandom_range(0, 2) +: 8] = 8'($urandom);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) src_valid = 3'($urandom);
            clear = ($urandom_range(0, 399) == 0);
            tick();
        end
        clear = 1'b0;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
